// File: rtl/lock_key_sender_if.sv
// Code/control bundle between the lock test harness and the lock key sender.
// The harness drives start/key writes and the lock's unlocked flag; the sender drives code and status.
interface lock_key_sender_if #(
  parameter int NUM_STEPS = 4,
  parameter int CODE_W    = 8,
  parameter int MAX_TRIES = 3
);
  localparam int IDX_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic              start;
  logic              key_we;
  logic [IDX_W-1:0]  key_idx;
  logic [CODE_W-1:0] key_wdata;
  logic [CODE_W-1:0] code;
  logic              unlocked;
  logic              busy;
  logic              done;
  logic              fail;
  logic [TRY_W-1:0]  tries;

  modport master (
    output start, key_we, key_idx, key_wdata, unlocked,
    input  code, busy, done, fail, tries
  );

  modport slave (
    input  start, key_we, key_idx, key_wdata, unlocked,
    output code, busy, done, fail, tries
  );
endinterface

// File: rtl/lock_key_sender.sv
// Lock key sender: plays a programmable code sequence into a lock, retries a bounded
// number of times and reports done or fail.
//
// state | meaning
// IDLE  | nothing sent yet since reset
// SEND  | driving key[step] onto code, one per cycle
// WAIT  | idle code driven, waiting for the lock to report unlocked
// FLUSH | one idle-code cycle so the lock returns to its start state
// DONE  | lock reported unlocked (sticky until next start)
// FAIL  | all attempts used without an unlock (sticky until next start)
module lock_key_sender #(
  parameter int                NUM_STEPS   = 4,
  parameter int                CODE_W      = 8,
  parameter int                WAIT_CYCLES = 3,
  parameter int                MAX_TRIES   = 3,
  parameter logic [CODE_W-1:0] IDLE_CODE   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  lock_key_sender_if.slave    bus
);
  localparam int IDX_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(NUM_STEPS - 1);
  localparam logic [WCNT_W-1:0] LAST_WAIT = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0]  TRY_ONE   = TRY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FLUSH,
    S_DONE,
    S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    step_q, step_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [CODE_W-1:0]   key_q [NUM_STEPS];

  logic ready;
  logic active;

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
  assign active = (state_q == S_SEND) || (state_q == S_WAIT) || (state_q == S_FLUSH);

  // Table is only writable while no attempt is in flight, so a sequence never changes mid-send.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STEPS; i++) key_q[i] <= '0;
    end else if (ready && bus.key_we && (int'(bus.key_idx) < NUM_STEPS)) begin
      key_q[bus.key_idx] <= bus.key_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    tries_d = tries_q;
    code_d  = IDLE_CODE;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.start) begin
          state_d = S_SEND;
          step_d  = '0;
          tries_d = TRY_ONE;
        end
      end
      S_SEND: begin
        code_d = key_q[step_q];
        if (step_q == LAST_STEP) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wcnt_q == LAST_WAIT) begin
          state_d = (tries_q >= TRY_MAX) ? S_FAIL : S_FLUSH;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_SEND;
        step_d  = '0;
        if (tries_q < TRY_MAX) tries_d = tries_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // An unlock ends the attempt from anywhere in flight, even part-way through the sequence.
    if (active && bus.unlocked) begin
      state_d = S_DONE;
      code_d  = IDLE_CODE;
    end

    busy_d = (state_d == S_SEND) || (state_d == S_WAIT) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      wcnt_q  <= '0;
      tries_q <= '0;
      code_q  <= IDLE_CODE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      tries_q <= tries_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.fail  = fail_q;
  assign bus.tries = tries_q;
endmodule
